// File: rtl/mux_16_1_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mux_16_1_serializer
// Description : Captures 16 parallel neuron words and streams them out over a
//               valid/ready interface, slot 0 (MSB word) first. Define
//               SERIALIZER_LAST_EN to add the out_last frame-end marker.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_16_1_serializer #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [16*WIDTH-1:0] data_in,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [3:0]          out_sel,
    output logic                done
`ifdef SERIALIZER_LAST_EN
    ,
    output logic                out_last
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_SLOT = 4'd15;

    state_t           state_q;
    logic [WIDTH-1:0] buf_q [16];
    logic [WIDTH-1:0] out_data_q;
    logic [3:0]       out_sel_q;
    logic [3:0]       sel_d;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             w_handshake;

    assign sel_d       = out_sel_q + 4'd1;
    assign w_handshake = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        // Slot 0 lives in the most significant word.
                        for (int i = 0; i < 16; i++) begin
                            buf_q[i] <= data_in[(15-i)*WIDTH +: WIDTH];
                        end
                        out_data_q  <= data_in[15*WIDTH +: WIDTH];
                        out_sel_q   <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_handshake) begin
                        if (out_sel_q == c_LAST_SLOT) begin
                            out_valid_q <= 1'b0;
                            out_sel_q   <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= FINISH;
                        end else begin
                            out_sel_q  <= sel_d;
                            out_data_q <= buf_q[sel_d];
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign done      = done_q;

`ifdef SERIALIZER_LAST_EN
    assign out_last = out_valid_q && (out_sel_q == c_LAST_SLOT);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_16_1_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_16_1_serializer
// Description : Self-checking bench; vector table plus randomized streams
//               scored against a word-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_16_1_serializer;

    localparam int c_W = 16;

    logic              clk;
    logic              rst_n;
    logic              load;
    logic [16*c_W-1:0] data_in;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [c_W-1:0]    out_data;
    logic [3:0]        out_sel;
    logic              done;
`ifdef SERIALIZER_LAST_EN
    logic              out_last;
`endif

    int checks = 0;
    int errors = 0;

    mux_16_1_serializer #(.WIDTH(c_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .done      (done)
`ifdef SERIALIZER_LAST_EN
        ,
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
    // inj: slot index at which a stray all-ones load is issued (>15 = none).
    // cycles: expected stream length in cycles, -1 when ready is random.
    typedef struct packed {
        logic [15:0][15:0] words;
        logic [1:0]        mode;
        int                inj;
        int                cycles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16*c_W-1:0] pack(input logic [15:0][15:0] w);
        logic [16*c_W-1:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) d = (d << c_W) | (16*c_W)'(w[i]);
        return d;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [15:0] exp_q[$];
        int  k;
        bit  r;
        bit  injected;
        exp_q    = {};
        injected = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(v.words[i]);
        @(negedge clk);
        data_in   = pack(v.words);
        load      = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        load    = 1'b0;
        data_in = {8{$urandom}};
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        k = 0;
        while (exp_q.size() > 0 && k < 300) begin
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("done_low", {31'd0, done}, 32'd0);
            chk("sel", {28'd0, out_sel}, 32'(16 - exp_q.size()));
            chk("data", {16'd0, out_data}, {16'd0, exp_q[0]});
`ifdef SERIALIZER_LAST_EN
            chk("last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
`endif
            case (v.mode)
                2'd0:    r = 1'b1;
                2'd1:    r = (k % 3 == 0);
                default: r = 1'($urandom % 2);
            endcase
            out_ready = r;
            if (!injected && v.inj == 16 - exp_q.size()) begin
                load     = 1'b1;
                data_in  = {16{16'hFFFF}};
                injected = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            if (r) void'(exp_q.pop_front());
            k++;
        end
        load = 1'b0;
        chk("words_left", 32'(exp_q.size()), 32'd0);
        if (v.cycles >= 0) chk("stream_cycles", 32'(k), 32'(v.cycles));
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_fin", {31'd0, busy}, 32'd0);
        chk("valid_fin", {31'd0, out_valid}, 32'd0);
        chk("sel_wrap", {28'd0, out_sel}, 32'd0);
`ifdef SERIALIZER_LAST_EN
        chk("last_fin", {31'd0, out_last}, 32'd0);
`endif
        @(negedge clk);
        chk("done_once", {31'd0, done}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("idle_valid2", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[6];
    vec_t rv;
    logic [15:0][15:0] ramp;
    logic [15:0][15:0] ones;
    logic [15:0][15:0] edge_w;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ramp[i]   = 16'h0100 + 16'(i);
            ones[i]   = 16'hFFFF;
            edge_w[i] = (i == 0) ? 16'hA5A5 : 16'h0000;
        end
        vecs[0] = '{words: ramp,   mode: 2'd0, inj: 99, cycles: 16};
        vecs[1] = '{words: ramp,   mode: 2'd1, inj: 99, cycles: 46};
        vecs[2] = '{words: ramp,   mode: 2'd0, inj: 5,  cycles: 16};
        vecs[3] = '{words: ones,   mode: 2'd0, inj: 99, cycles: 16};
        vecs[4] = '{words: edge_w, mode: 2'd2, inj: 99, cycles: -1};
        vecs[5] = '{words: ramp,   mode: 2'd2, inj: 15, cycles: -1};

        rst_n     = 1'b0;
        load      = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_sel", {28'd0, out_sel}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
`ifdef SERIALIZER_LAST_EN
        chk("rst_last", {31'd0, out_last}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset mid-stream at slot 8.
        @(negedge clk);
        data_in   = pack(ramp);
        load      = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 40 && out_sel != 4'd8; i++) @(negedge clk);
        chk("reach_sel8", {28'd0, out_sel}, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_sel", {28'd0, out_sel}, 32'd0);
        chk("arst_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
            chk("post_rst_done", {31'd0, done}, 32'd0);
        end
        out_ready = 1'b0;

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) rv.words[i] = 16'($urandom);
            rv.mode   = 2'd2;
            rv.inj    = int'($urandom_range(0, 20));
            rv.cycles = -1;
            run_vec(rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
